simon_datapath: RTL and testbench
=================================

Name: simon_datapath

Overview:
- Datapath partner to the Simon control FSM. It consumes the FSM's control strobes (clear_i, increment_n, increment_i, write_pattern, input_led_pattern) and returns its status inputs (valid_input, valid_repeat, seq_remain).
- Holds the pattern memory, the stored-length counter n and the playback/repeat index i.
- Synchronizes the user switch pattern and drives the pattern LEDs.

Parameters:
- PATTERN_W, 4: width of one pattern (one switch/LED per bit).
- DEPTH, 64: maximum number of stored patterns.
- SYNC_STAGES, 2: flop stages on the switch input. Minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- pattern  input  PATTERN_W  raw user switches, asynchronous to clk.
- clear_i  input  1  zero the index i.
- increment_i  input  1  advance i.
- increment_n  input  1  advance the stored count n.
- write_pattern  input  1  write the synchronized pattern to mem[n].
- input_led_pattern  input  1  LEDs show the switches (1) or mem[i] (0).
- valid_input  output  1  switches are one-hot and memory is not full.
- valid_repeat  output  1  switches equal mem[i].
- seq_remain  output  1  i is not the last stored entry.
- pattern_leds  output  PATTERN_W  LED drive.

Behaviour:
- Width rule: CW = clog2(DEPTH)+1.
  - n and i are CW-bit unsigned.
  - Memory is DEPTH x PATTERN_W, written synchronously and read combinationally.
- Synchronizer: pattern passes through SYNC_STAGES flops to give sync_pat. Latency is SYNC_STAGES cycles. All comparisons and writes use sync_pat only.
- rst low, asynchronously and immediately, including mid-operation:
  - n=0, i=0, all sync flops=0.
  - Memory contents are not reset; they are unreachable while n=0.
- Resulting output values during and after reset:
  - seq_remain=0.
  - valid_input=0, because sync_pat=0 is not one-hot.
  - valid_repeat=0 while n=0.
  - pattern_leds = input_led_pattern ? 0 : mem[0]. mem[0] is don't-care at this point.
- valid_input (combinational) = (sync_pat has exactly one bit set) && (n < DEPTH).
- valid_repeat (combinational) = (n != 0) && (i < n) && (sync_pat == mem[i]).
- seq_remain (combinational) = (i + 1 < n), evaluated at CW+1 bits. It is 0 when n=0.
- pattern_leds (combinational) = input_led_pattern ? sync_pat : mem[i[CW-2:0]].
- write_pattern at a clock edge:
  - If n < DEPTH, mem[n] <= sync_pat.
  - If n == DEPTH, the write is ignored.
- increment_n at a clock edge: n <= n+1 if n < DEPTH, else n holds (saturates at DEPTH).
- write_pattern and increment_n in the same cycle: the write uses the pre-increment n. This is the normal case.
- i update priority, evaluated at each edge:
  1. clear_i: i <= 0. Wins over increment_i when both are asserted.
  2. increment_i and i+1 >= n: i <= 0 (wrap safety).
  3. increment_i: i <= i+1.
  4. Otherwise i holds.
- No internal state machine. All sequencing comes from the control block; the datapath is a counter/memory slave with single-cycle strobe response.

Test Plan:
1. Reset: rst=0 asynchronously mid-run with clk stopped → n=0, i=0, seq_remain=0, valid_input=0 at once. Release rst, apply pattern=4'b0100 → valid_input=1 after exactly 2 edges.
2. Input: sync_pat=4'b0100, one-cycle pulse of write_pattern+increment_n → mem[0]=0100, n=1. Then pattern=4'b0110 (after sync) → valid_input=0. Then pattern=4'b0000 → valid_input=0.
3. Playback: store 0001, 0010, 1000 (n=3), input_led_pattern=0, increment_i each cycle → pattern_leds=0001, 0010, 1000 with seq_remain=1, 1, 0.
4. Repeat: n=3, i=1, input_led_pattern=1:
   - sync_pat=0010 → valid_repeat=1 and pattern_leds=0010.
   - sync_pat=0100 → valid_repeat=0.
5. Full: 64 valid writes → n=64, valid_input=0 for sync_pat=0001. A further write_pattern+increment_n leaves n=64 and mem unchanged (mem[63] readback intact).
6. Index boundaries:
   - i=2, clear_i and increment_i together → i=0.
   - i=2, n=3, increment_i alone → i wraps to 0.

Source files
------------

// File: rtl/simon_datapath.sv
`timescale 1ns/1ps
// Simon datapath: switch synchronizer, pattern memory, stored-count n and playback index i.
// Latency: switches reach sync_pat after SYNC_STAGES edges; strobes act on the next edge; status outputs are combinational.
// Backpressure: none; the control FSM sequences every strobe, and the datapath responds in one cycle.
module simon_datapath #(
  parameter int PATTERN_W   = 4,
  parameter int DEPTH       = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 clear_i,
  input  logic                 increment_i,
  input  logic                 increment_n,
  input  logic                 write_pattern,
  input  logic                 input_led_pattern,
  output logic                 valid_input,
  output logic                 valid_repeat,
  output logic                 seq_remain,
  output logic [PATTERN_W-1:0] pattern_leds
);

  // n and i can reach DEPTH itself, so they need one bit more than the address.
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   ONE_X   = (CW+1)'(1);

  logic [PATTERN_W-1:0] sync_q [SYNC_STAGES];
  logic [PATTERN_W-1:0] sync_d [SYNC_STAGES];
  logic [PATTERN_W-1:0] sync_pat;

  logic [PATTERN_W-1:0] mem_q [DEPTH];
  logic                 mem_we;
  logic [PATTERN_W-1:0] mem_rd;

  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] i_q, i_d;
  logic          not_full;
  logic [CW:0]   i_plus1_x;

  // Shift chain for the asynchronous switches; only the last stage is used downstream.
  always_comb begin
    sync_d[0] = pattern;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Synchronizer flops, cleared on reset so the cleared value reads as "no valid switch".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign sync_pat  = sync_q[SYNC_STAGES-1];
  assign not_full  = (n_q < DEPTH_C);
  assign i_plus1_x = {1'b0, i_q} + ONE_X;
  assign mem_rd    = mem_q[i_q[AW-1:0]];

  // Counter next-state: n saturates at DEPTH; clear beats increment; i wraps to 0 past the last entry.
  always_comb begin
    n_d    = n_q;
    i_d    = i_q;
    mem_we = write_pattern && not_full;
    if (increment_n && not_full) begin
      n_d = n_q + CW'(1);
    end
    if (clear_i) begin
      i_d = '0;
    end else if (increment_i) begin
      if (i_plus1_x >= {1'b0, n_q}) begin
        i_d = '0;
      end else begin
        i_d = i_q + CW'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_q <= '0;
      i_q <= '0;
    end else begin
      n_q <= n_d;
      i_q <= i_d;
    end
  end

  // Pattern memory: the write address is the pre-increment n. Contents survive reset but are unreachable while n is 0.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[n_q[AW-1:0]] <= sync_pat;
    end
  end

  // Status outputs and LED mux back to the control FSM.
  always_comb begin
    valid_input  = $onehot(sync_pat) && not_full;
    valid_repeat = (n_q != '0) && (i_q < n_q) && (sync_pat == mem_rd);
    seq_remain   = (i_plus1_x < {1'b0, n_q});
    pattern_leds = input_led_pattern ? sync_pat : mem_rd;
  end

endmodule

// File: tb/tb_simon_datapath.sv
`timescale 1ns/1ps
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst;
  logic [3:0] pattern;
  logic       clear_i, increment_i, increment_n, write_pattern, input_led_pattern;
  logic       valid_input, valid_repeat, seq_remain;
  logic [3:0] pattern_leds;

  int n_cmp = 0;
  int n_bad = 0;

  simon_datapath #(.PATTERN_W(4), .DEPTH(64), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .pattern           (pattern),
    .clear_i           (clear_i),
    .increment_i       (increment_i),
    .increment_n       (increment_n),
    .write_pattern     (write_pattern),
    .input_led_pattern (input_led_pattern),
    .valid_input       (valid_input),
    .valid_repeat      (valid_repeat),
    .seq_remain        (seq_remain),
    .pattern_leds      (pattern_leds)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present p on the switches, let it settle through the synchronizer, then store it.
  task automatic store(input logic [3:0] p);
    pattern = p;
    tick();
    tick();
    write_pattern = 1'b1;
    increment_n   = 1'b1;
    tick();
    write_pattern = 1'b0;
    increment_n   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pattern = 4'b0000;
    clear_i = 1'b0;
    increment_i = 1'b0;
    increment_n = 1'b0;
    write_pattern = 1'b0;
    input_led_pattern = 1'b1;
    tick();
    tick();
    check("rst_n", dut.n_q, 0);
    check("rst_i", dut.i_q, 0);
    check("rst_seq_remain", seq_remain, 0);
    check("rst_valid_input", valid_input, 0);
    check("rst_valid_repeat", valid_repeat, 0);
    check("rst_leds", pattern_leds, 4'b0000);
    rst = 1'b1;

    // Synchronizer latency: exactly two edges.
    pattern = 4'b0100;
    tick();
    check("sync_1edge_valid_input", valid_input, 0);
    tick();
    check("sync_2edge_valid_input", valid_input, 1);

    // Input: store 0100, then reject non-one-hot and zero.
    write_pattern = 1'b1;
    increment_n   = 1'b1;
    tick();
    write_pattern = 1'b0;
    increment_n   = 1'b0;
    check("input_n1", dut.n_q, 1);
    input_led_pattern = 1'b0;
    check("input_mem0", pattern_leds, 4'b0100);
    pattern = 4'b0110;
    tick();
    tick();
    check("input_twohot_valid", valid_input, 0);
    pattern = 4'b0000;
    tick();
    tick();
    check("input_zero_valid", valid_input, 0);

    // Playback: fresh sequence 0001, 0010, 1000.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    store(4'b0001);
    store(4'b0010);
    store(4'b1000);
    check("play_n3", dut.n_q, 3);
    input_led_pattern = 1'b0;
    check("play_leds0", pattern_leds, 4'b0001);
    check("play_seq0", seq_remain, 1);
    increment_i = 1'b1;
    tick();
    check("play_leds1", pattern_leds, 4'b0010);
    check("play_seq1", seq_remain, 1);
    tick();
    increment_i = 1'b0;
    check("play_leds2", pattern_leds, 4'b1000);
    check("play_seq2", seq_remain, 0);

    // Index boundaries: clear beats increment, then wrap at the last entry.
    clear_i = 1'b1;
    increment_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_prio_i", dut.i_q, 0);
    check("clr_prio_leds", pattern_leds, 4'b0001);
    tick();
    tick();
    check("wrap_pre_i", dut.i_q, 2);
    tick();
    increment_i = 1'b0;
    check("wrap_i", dut.i_q, 0);
    check("wrap_seq", seq_remain, 1);

    // Repeat: i=1 against the switches.
    increment_i = 1'b1;
    tick();
    increment_i = 1'b0;
    input_led_pattern = 1'b1;
    pattern = 4'b0010;
    tick();
    tick();
    check("rep_match_valid", valid_repeat, 1);
    check("rep_match_leds", pattern_leds, 4'b0010);
    pattern = 4'b0100;
    tick();
    tick();
    check("rep_miss_valid", valid_repeat, 0);
    check("rep_miss_valid_input", valid_input, 1);

    // Full: fill entries 3..62 with 0001, then 1000 into entry 63.
    pattern = 4'b0001;
    tick();
    tick();
    write_pattern = 1'b1;
    increment_n   = 1'b1;
    for (int k = 0; k < 60; k++) tick();
    write_pattern = 1'b0;
    increment_n   = 1'b0;
    check("full_n63", dut.n_q, 63);
    check("full_n63_valid_input", valid_input, 1);
    store(4'b1000);
    check("full_n64", dut.n_q, 64);
    pattern = 4'b0001;
    tick();
    tick();
    check("full_valid_input_0001", valid_input, 0);
    pattern = 4'b0100;
    tick();
    tick();
    check("full_valid_input_0100", valid_input, 0);
    write_pattern = 1'b1;
    increment_n   = 1'b1;
    tick();
    write_pattern = 1'b0;
    increment_n   = 1'b0;
    check("full_sat_n", dut.n_q, 64);
    input_led_pattern = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("full_mem0_intact", pattern_leds, 4'b0001);
    increment_i = 1'b1;
    for (int k = 0; k < 63; k++) tick();
    increment_i = 1'b0;
    check("full_i63", dut.i_q, 63);
    check("full_mem63_intact", pattern_leds, 4'b1000);
    check("full_seq_last", seq_remain, 0);
    input_led_pattern = 1'b1;
    pattern = 4'b1000;
    tick();
    tick();
    check("full_repeat_last", valid_repeat, 1);
    increment_i = 1'b1;
    tick();
    increment_i = 1'b0;
    check("full_i_wrap", dut.i_q, 0);

    // Asynchronous reset mid-operation with the clock stopped.
    @(negedge clk);
    clk_run = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_n", dut.n_q, 0);
    check("arst_i", dut.i_q, 0);
    check("arst_seq_remain", seq_remain, 0);
    check("arst_valid_input", valid_input, 0);
    check("arst_valid_repeat", valid_repeat, 0);
    check("arst_leds", pattern_leds, 4'b0000);
    rst = 1'b1;
    pattern = 4'b0100;
    #1;
    clk_run = 1'b1;
    tick();
    check("arst_sync_1edge", valid_input, 0);
    tick();
    check("arst_sync_2edge", valid_input, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
